// File: rtl/hazard_pkg.sv
// Shared types and defaults for the pipeline hazard controller.
package hazard_pkg;

    typedef enum logic [1:0] {
        HZ_RUN     = 2'd0,
        HZ_FLUSH   = 2'd1,
        HZ_MEMWAIT = 2'd2,
        HZ_RSVD    = 2'd3
    } hz_state_t;

    localparam logic [4:0] XZR = 5'd31;

    localparam int FLUSH_LEN_DEF   = 1;
    localparam int MEM_TIMEOUT_DEF = 255;

    localparam int REM_W  = 3;
    localparam int WAIT_W = 10;

endpackage

// File: rtl/hz_load_use_det.sv
// Load-use comparator: a load in execute feeding a source read in decode.
module hz_load_use_det
    import hazard_pkg::*;
(
    input  logic [4:0] id_rn,
    input  logic [4:0] id_rm,
    input  logic       id_uses_rn,
    input  logic       id_uses_rm,
    input  logic [4:0] ex_rd,
    input  logic       ex_mem2reg,
    input  logic       ex_regwe,
    output logic       hit
);

    logic rn_match, rm_match;

    assign rn_match = id_uses_rn && (id_rn == ex_rd);
    assign rm_match = id_uses_rm && (id_rm == ex_rd);

    // XZR is hard-wired zero, so a load "into" it never creates a dependency.
    assign hit = ex_mem2reg && ex_regwe && (ex_rd != XZR) && (rn_match || rm_match);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, branch flush, memory-wait hold.
// Define HAZARD_PERF_CNT_EN to add stall_cycles / flush_events counters.
module pipe_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int FLUSH_LEN   = FLUSH_LEN_DEF,
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [4:0]  id_rn,
    input  logic [4:0]  id_rm,
    input  logic        id_uses_rn,
    input  logic        id_uses_rm,
    input  logic [4:0]  ex_rd,
    input  logic        ex_mem2reg,
    input  logic        ex_regwe,
    input  logic        ex_pc_src,
    input  logic        mem_busy,
    output logic        pc_we,
    output logic        ifid_we,
    output logic        idex_we,
    output logic        exmem_we,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic [1:0]  hz_state,
    output logic        mem_timeout
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_events
`endif
);

    localparam logic [REM_W-1:0]  FLUSH_REM   = REM_W'(FLUSH_LEN - 1);
    localparam logic [WAIT_W-1:0] TIMEOUT_LIM = WAIT_W'(MEM_TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_MAX    = '1;

    hz_state_t         state_q, state_d, resume_q, resume_d, act_state;
    logic [REM_W-1:0]  rem_q, rem_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              timeout_q, timeout_d;
    logic              lu_hit;
    logic              branch_take;

    hz_load_use_det u_lu_det (
        .id_rn      (id_rn),
        .id_rm      (id_rm),
        .id_uses_rn (id_uses_rn),
        .id_uses_rm (id_uses_rm),
        .ex_rd      (ex_rd),
        .ex_mem2reg (ex_mem2reg),
        .ex_regwe   (ex_regwe),
        .hit        (lu_hit)
    );

    // The cycle busy drops, MEMWAIT behaves exactly like the state it interrupted.
    always_comb begin
        act_state = state_q;
        if (state_q == HZ_MEMWAIT && !mem_busy)
            act_state = resume_q;
    end

    assign branch_take = !mem_busy && (act_state == HZ_RUN) && ex_pc_src;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= HZ_RUN;
            resume_q  <= HZ_RUN;
            rem_q     <= '0;
            wait_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            resume_q  <= resume_d;
            rem_q     <= rem_d;
            wait_q    <= wait_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        resume_d = resume_q;
        rem_d    = rem_q;
        case (state_q)
            HZ_RUN, HZ_FLUSH, HZ_MEMWAIT: begin
                if (mem_busy) begin
                    state_d = HZ_MEMWAIT;
                    if (state_q != HZ_MEMWAIT)
                        resume_d = state_q;
                end else if (act_state == HZ_FLUSH) begin
                    rem_d   = (rem_q == '0) ? '0 : rem_q - 1'b1;
                    state_d = (rem_q <= REM_W'(1)) ? HZ_RUN : HZ_FLUSH;
                end else begin
                    state_d = HZ_RUN;
                    if (ex_pc_src && FLUSH_LEN > 1) begin
                        state_d = HZ_FLUSH;
                        rem_d   = FLUSH_REM;
                    end
                end
            end
            default: begin
                state_d  = HZ_RUN;
                resume_d = HZ_RUN;
                rem_d    = '0;
            end
        endcase
    end

    // wait_q counts MEMWAIT cycles including the current one.
    always_comb begin
        wait_d = '0;
        if (state_d == HZ_MEMWAIT) begin
            if (state_q != HZ_MEMWAIT)      wait_d = WAIT_W'(1);
            else if (wait_q == WAIT_MAX)    wait_d = wait_q;
            else                            wait_d = wait_q + 1'b1;
        end
        timeout_d = timeout_q || (state_d == HZ_MEMWAIT && wait_d >= TIMEOUT_LIM);
    end

    always_comb begin
        pc_we      = 1'b0;
        ifid_we    = 1'b0;
        idex_we    = 1'b0;
        exmem_we   = 1'b0;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        if (!reset_n) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (!mem_busy) begin
            case (act_state)
                HZ_RUN: begin
                    if (ex_pc_src) begin
                        {pc_we, ifid_we, idex_we, exmem_we} = 4'b1111;
                        ifid_flush = 1'b1;
                        idex_flush = 1'b1;
                    end else if (lu_hit) begin
                        idex_we    = 1'b1;
                        exmem_we   = 1'b1;
                        idex_flush = 1'b1;
                    end else begin
                        {pc_we, ifid_we, idex_we, exmem_we} = 4'b1111;
                    end
                end
                HZ_FLUSH: begin
                    {pc_we, ifid_we, idex_we, exmem_we} = 4'b1111;
                    ifid_flush = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign hz_state    = state_q;
    assign mem_timeout = timeout_q;

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cycles <= '0;
            flush_events <= '0;
        end else begin
            if (!pc_we && stall_cycles != '1)
                stall_cycles <= stall_cycles + 1'b1;
            if (branch_take && flush_events != '1)
                flush_events <= flush_events + 1'b1;
        end
    end
`else
    logic unused_branch_take;
    assign unused_branch_take = branch_take;
`endif

endmodule
